jpeg_ziguzagu_ctrl: RTL

JPEG_ZIGUZAGU_CTRL -- requirements
Module: jpeg_ziguzagu_ctrl

---
 rtl/jpeg_ziguzagu_ctrl_if.sv | 25 ++
 rtl/jpeg_ziguzagu_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/jpeg_ziguzagu_ctrl_if.sv
// Coefficient input, zigzag register-array write port and block handshake
// of jpeg_ziguzagu_ctrl; master is the entropy-decoder/IDCT side.
interface jpeg_ziguzagu_ctrl_if;
    logic        CoefEnable;
    logic        CoefReady;
    logic [3:0]  CoefRun;
    logic [15:0] CoefValue;
    logic        CoefEob;
    logic        ZzEnable;
    logic [5:0]  ZzAddress;
    logic [15:0] ZzData;
    logic        BlockValid;
    logic        BlockAck;
    logic        BlockError;

    modport master (
        output CoefEnable, CoefRun, CoefValue, CoefEob, BlockAck,
        input  CoefReady, ZzEnable, ZzAddress, ZzData, BlockValid, BlockError
    );

    modport slave (
        input  CoefEnable, CoefRun, CoefValue, CoefEob, BlockAck,
        output CoefReady, ZzEnable, ZzAddress, ZzData, BlockValid, BlockError
    );
endinterface

// File: rtl/jpeg_ziguzagu_ctrl.sv
// Zigzag write controller: turns run/value coefficients into register-array writes
// and hands complete 8x8 blocks to the IDCT. Define JPEG_ZZ_RUNCHK_EN for run-overflow checking.
module jpeg_ziguzagu_ctrl (
    input  logic                  rst,
    input  logic                  clk,
    jpeg_ziguzagu_ctrl_if.slave   zz
);

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        FLUSH  = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  k_q, k_d;
    logic        zz_en_q, zz_en_d;
    logic [5:0]  zz_addr_q, zz_addr_d;
    logic [15:0] zz_data_q, zz_data_d;
    logic [5:0]  ac_addr;

`ifdef JPEG_ZZ_RUNCHK_EN
    logic        err_q, err_d;
    logic [6:0]  run_sum;

    assign run_sum = k_q + {3'b000, zz.CoefRun};
    assign ac_addr = run_sum[5:0];
`else
    // Without overflow checking the AC address simply wraps modulo 64.
    assign ac_addr = k_q[5:0] + {2'b00, zz.CoefRun};
`endif

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        zz_en_d   = 1'b0;
        zz_addr_d = zz_addr_q;
        zz_data_d = zz_data_q;
`ifdef JPEG_ZZ_RUNCHK_EN
        err_d     = err_q;
`endif
        case (state_q)
            ACCEPT: begin
                if (zz.CoefEnable) begin
                    if (zz.CoefEob) begin
                        // EOB on an empty block still writes a zero DC to clear the array.
                        if (k_q == '0) begin
                            zz_en_d   = 1'b1;
                            zz_addr_d = '0;
                            zz_data_d = '0;
                        end
                        state_d = FLUSH;
                    end else if (k_q == '0) begin
                        zz_en_d   = 1'b1;
                        zz_addr_d = '0;
                        zz_data_d = zz.CoefValue;
                        k_d       = 7'd1;
                    end
`ifdef JPEG_ZZ_RUNCHK_EN
                    else if (run_sum > 7'd63) begin
                        err_d   = 1'b1;
                        state_d = FLUSH;
                    end
`endif
                    else begin
                        zz_en_d   = 1'b1;
                        zz_addr_d = ac_addr;
                        zz_data_d = zz.CoefValue;
                        k_d       = {1'b0, ac_addr} + 7'd1;
                        if (ac_addr == 6'd63) begin
                            state_d = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (zz.BlockAck) begin
                    state_d = ACCEPT;
                    k_d     = '0;
`ifdef JPEG_ZZ_RUNCHK_EN
                    err_d   = 1'b0;
`endif
                end
            end
            default: begin
                state_d = ACCEPT;
                k_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ACCEPT;
            k_q       <= '0;
            zz_en_q   <= 1'b0;
            zz_addr_q <= '0;
            zz_data_q <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            zz_en_q   <= zz_en_d;
            zz_addr_q <= zz_addr_d;
            zz_data_q <= zz_data_d;
        end
    end

`ifdef JPEG_ZZ_RUNCHK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign zz.BlockError = err_q;
`else
    assign zz.BlockError = 1'b0;
`endif

    assign zz.CoefReady  = (state_q == ACCEPT);
    assign zz.BlockValid = (state_q == HOLD);
    assign zz.ZzEnable   = zz_en_q;
    assign zz.ZzAddress  = zz_addr_q;
    assign zz.ZzData     = zz_data_q;

endmodule
